// File: rtl/irq_ctl.sv
// Interrupt controller: synchronizes sources, masks and prioritizes them, and runs the irq/iack/EOI handshake.
// Define IRQ_EDGE_DETECT_EN for edge-latched pending bits; the default build treats sources as levels.
module irq_ctl #(
  parameter int unsigned N_SRC      = 8,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0050,
  parameter int unsigned VEC_STRIDE = 8
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] src_i,
  output logic             irq_o,
  output logic [31:0]      irq_addr_o,
  input  logic             iack_i,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_addr_i,
  input  logic [31:0]      cfg_din_i,
  output logic [31:0]      cfg_dout_o
);

  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_PEND = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;
  localparam logic [1:0] A_EOI  = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, SERV, GAP} state_t;

  state_t           state, state_n;
  logic [N_SRC-1:0] sync1, sync2, mask, pend, pend_n, active;
  logic [4:0]       id, id_n;
  logic             busy, take, ack;
  logic             wr_mask, wr_pend, wr_eoi;
  logic [31:0]      rd_data;
  logic             unused_ok;

  assign wr_mask   = cfg_we_i && (cfg_addr_i == A_MASK);
  assign wr_pend   = cfg_we_i && (cfg_addr_i == A_PEND);
  assign wr_eoi    = cfg_we_i && (cfg_addr_i == A_EOI);
  assign active    = pend & mask;
  assign unused_ok = ^{wr_pend, cfg_din_i};

  // Lowest index wins: scan downward so the last hit is the smallest set bit.
  always_comb begin
    id_n = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (active[k]) id_n = 5'(k);
    end
  end

`ifdef IRQ_EDGE_DETECT_EN
  logic [N_SRC-1:0] sync_d, clr_vec;

  // Clears come from W1C and from the acknowledged source; a coincident new edge wins.
  always_comb begin
    clr_vec = '0;
    if (wr_pend) clr_vec = cfg_din_i[N_SRC-1:0];
    if (ack)     clr_vec = clr_vec | (N_SRC'(1) << id);
    pend_n = (pend & ~clr_vec) | (sync2 & ~sync_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_i) sync_d <= '0;
    else        sync_d <= sync2;
  end
`else
  always_comb begin
    pend_n = sync2;
  end
`endif

  // Handshake: irq_o stays high from the IDLE->REQ commit until iack_i is
  // sampled high at a rising edge; only that edge transfers the request, and
  // irq_o is low after it. iack_i outside REQ has no effect.
  always_comb begin
    state_n = state;
    take    = 1'b0;
    ack     = 1'b0;
    case (state)
      IDLE: if (|active) begin state_n = REQ; take = 1'b1; end
      REQ:  if (iack_i)  begin state_n = SERV; ack = 1'b1; end
      SERV: if (wr_eoi)  state_n = GAP;
      GAP:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (cfg_addr_i)
      A_MASK:  rd_data = 32'(mask);
      A_PEND:  rd_data = 32'(pend);
      A_STAT:  rd_data = {busy, 26'b0, id};
      default: rd_data = '0;
    endcase
  end

  assign irq_o = (state == REQ);

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state      <= IDLE;
      sync1      <= '0;
      sync2      <= '0;
      mask       <= '0;
      pend       <= '0;
      id         <= '0;
      busy       <= 1'b0;
      irq_addr_o <= VEC_BASE;
      cfg_dout_o <= '0;
    end else begin
      state      <= state_n;
      sync1      <= src_i;
      sync2      <= sync1;
      pend       <= pend_n;
      cfg_dout_o <= rd_data;
      if (wr_mask) mask <= cfg_din_i[N_SRC-1:0];
      if (take) begin
        id         <= id_n;
        irq_addr_o <= VEC_BASE + 32'(id_n) * VEC_STRIDE;
      end else if (state == GAP) begin
        id <= '0;
      end
      if (ack)                busy <= 1'b1;
      else if (state == GAP)  busy <= 1'b0;
    end
  end

endmodule
